// File: rtl/aurora_ser_pkg.sv
// Shared definitions for the Aurora TX serializer.
//   - Header field positions and widths used to build the first beat of a frame.
//   - FSM state encoding.
//   - num_payload_beats(): ceiling division of the message width by the payload
//     bits carried per beat.
package aurora_ser_pkg;

    // Header beat layout (LSB first): flag, router id, TTL, destination.
    localparam int HDR_FLAG_BIT = 0;
    localparam int RID_LSB      = 1;
    localparam int TTL_LSB      = 3;
    localparam int DST_LSB      = 5;
    localparam int RID_WIDTH    = 2;
    localparam int TTL_WIDTH    = 2;

    // Payload beats carry the flag and router id below the data slice.
    localparam int PAYLOAD_LSB  = RID_LSB + RID_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2
    } ser_state_t;

    function automatic int num_payload_beats(input int send_w, input int payload_w);
        return (send_w + payload_w - 1) / payload_w;
    endfunction

endpackage

// File: rtl/aurora_tx_serializer.sv
// Aurora TX serializer: turns one wide host message plus routing fields into an
// AXI4-Stream frame of one header beat followed by NUM_PAYLOAD_BEATS payload
// beats. Requests with TTL==0 are consumed and dropped without any beats.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   send_data_valid/ready    request handshake (ready only in IDLE, not in reset)
//   v_data_read              host message, SEND_DATA_WIDTH bits
//   dst_addr_send            destination address
//   TTL_send, router_id_send routing fields
//   axis_tx_*                AXI4-Stream master toward the Aurora core
//   done_serializer          one-cycle pulse after the last beat handshake
//   drop_pulse               one-cycle pulse after a TTL==0 request is consumed
module aurora_tx_serializer
    import aurora_ser_pkg::*;
#(
    parameter int NUMBER_OF_LANE    = 1,
    parameter int AURORA_DATA_WIDTH = 64 * NUMBER_OF_LANE,
    parameter int SEND_DATA_WIDTH   = 1024,
    parameter int ADDR_WIDTH        = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         send_data_valid,
    output logic                         send_data_ready,
    input  logic [SEND_DATA_WIDTH-1:0]   v_data_read,
    input  logic [ADDR_WIDTH-1:0]        dst_addr_send,
    input  logic [TTL_WIDTH-1:0]         TTL_send,
    input  logic [RID_WIDTH-1:0]         router_id_send,
    output logic                         axis_tx_tvalid,
    input  logic                         axis_tx_tready,
    output logic                         axis_tx_tlast,
    output logic [AURORA_DATA_WIDTH-1:0] axis_tx_tdata,
    output logic                         done_serializer,
    output logic                         drop_pulse
);

    localparam int HOST_PAYLOAD_WIDTH = AURORA_DATA_WIDTH - PAYLOAD_LSB;
    localparam int NUM_PAYLOAD_BEATS  = num_payload_beats(SEND_DATA_WIDTH, HOST_PAYLOAD_WIDTH);
    localparam int CNT_WIDTH          = $clog2(NUM_PAYLOAD_BEATS + 1);
    localparam int EXT_WIDTH          = NUM_PAYLOAD_BEATS * HOST_PAYLOAD_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(NUM_PAYLOAD_BEATS - 1);

    ser_state_t                    r_state;
    ser_state_t                    w_state_next;

    logic [SEND_DATA_WIDTH-1:0]    r_data;
    logic [SEND_DATA_WIDTH-1:0]    w_data_next;
    logic [RID_WIDTH-1:0]          r_rid;
    logic [RID_WIDTH-1:0]          w_rid_next;
    logic [CNT_WIDTH-1:0]          r_cnt;
    logic [CNT_WIDTH-1:0]          w_cnt_next;
    logic                          r_tvalid;
    logic                          w_tvalid_next;
    logic                          r_tlast;
    logic                          w_tlast_next;
    logic [AURORA_DATA_WIDTH-1:0]  r_tdata;
    logic [AURORA_DATA_WIDTH-1:0]  w_tdata_next;
    logic                          r_done;
    logic                          w_done_next;
    logic                          r_drop;
    logic                          w_drop_next;

    logic                          w_accept;
    logic                          w_hs;
    logic                          w_is_last;
    logic [CNT_WIDTH-1:0]          w_sel;
    logic [EXT_WIDTH-1:0]          w_data_ext;
    logic [AURORA_DATA_WIDTH-1:0]  w_header;
    logic [AURORA_DATA_WIDTH-1:0]  w_payload_beat;

    // Message zero-extended to a whole number of beats so the last slice
    // is padded with zeros and no part-select ever leaves the vector.
    generate
        if (EXT_WIDTH > SEND_DATA_WIDTH) begin : g_pad
            assign w_data_ext = {{(EXT_WIDTH - SEND_DATA_WIDTH){1'b0}}, r_data};
        end else begin : g_nopad
            assign w_data_ext = r_data;
        end
    endgenerate

    assign send_data_ready = (r_state == S_IDLE) && !rst;
    assign w_accept        = send_data_valid && send_data_ready;
    assign w_hs            = r_tvalid && axis_tx_tready;
    assign w_is_last       = (r_cnt == LAST_BEAT);

    // Index of the payload slice to load on the next handshake. In HEADER it
    // is slice 0; in PAYLOAD it is the following slice. On the final beat no
    // further slice is needed, so the index is parked at 0 to stay in range.
    always_comb begin
        w_sel = '0;
        if (r_state == S_PAYLOAD && !w_is_last) begin
            w_sel = r_cnt + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        w_payload_beat = '0;
        w_payload_beat[RID_LSB +: RID_WIDTH] = r_rid;
        w_payload_beat[AURORA_DATA_WIDTH-1:PAYLOAD_LSB] =
            w_data_ext[int'(w_sel) * HOST_PAYLOAD_WIDTH +: HOST_PAYLOAD_WIDTH];
    end

    // Header is built straight from the request inputs because it is loaded
    // into the output register on the same edge the request is accepted.
    always_comb begin
        w_header = '0;
        w_header[HDR_FLAG_BIT]             = 1'b1;
        w_header[RID_LSB +: RID_WIDTH]     = router_id_send;
        w_header[TTL_LSB +: TTL_WIDTH]     = TTL_send;
        w_header[DST_LSB +: ADDR_WIDTH]    = dst_addr_send;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_data_next   = r_data;
        w_rid_next    = r_rid;
        w_cnt_next    = r_cnt;
        w_tvalid_next = r_tvalid;
        w_tlast_next  = r_tlast;
        w_tdata_next  = r_tdata;
        w_done_next   = 1'b0;
        w_drop_next   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_data_next = v_data_read;
                    w_rid_next  = router_id_send;
                    if (TTL_send == '0) begin
                        w_drop_next = 1'b1;
                    end else begin
                        w_state_next  = S_HEADER;
                        w_tvalid_next = 1'b1;
                        w_tlast_next  = 1'b0;
                        w_tdata_next  = w_header;
                    end
                end
            end
            S_HEADER: begin
                if (w_hs) begin
                    w_state_next = S_PAYLOAD;
                    w_cnt_next   = '0;
                    w_tdata_next = w_payload_beat;
                    w_tlast_next = (LAST_BEAT == '0);
                end
            end
            S_PAYLOAD: begin
                if (w_hs) begin
                    if (w_is_last) begin
                        w_state_next  = S_IDLE;
                        w_cnt_next    = '0;
                        w_tvalid_next = 1'b0;
                        w_tlast_next  = 1'b0;
                        w_tdata_next  = '0;
                        w_done_next   = 1'b1;
                    end else begin
                        w_cnt_next   = r_cnt + CNT_WIDTH'(1);
                        w_tdata_next = w_payload_beat;
                        w_tlast_next = ((r_cnt + CNT_WIDTH'(1)) == LAST_BEAT);
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data   <= '0;
            r_rid    <= '0;
            r_cnt    <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tdata  <= '0;
            r_done   <= 1'b0;
            r_drop   <= 1'b0;
        end else begin
            r_data   <= w_data_next;
            r_rid    <= w_rid_next;
            r_cnt    <= w_cnt_next;
            r_tvalid <= w_tvalid_next;
            r_tlast  <= w_tlast_next;
            r_tdata  <= w_tdata_next;
            r_done   <= w_done_next;
            r_drop   <= w_drop_next;
        end
    end

    assign axis_tx_tvalid  = r_tvalid;
    assign axis_tx_tlast   = r_tlast;
    assign axis_tx_tdata   = r_tdata;
    assign done_serializer = r_done;
    assign drop_pulse      = r_drop;

endmodule

// File: tb/tb_aurora_tx_serializer.sv
module tb_aurora_tx_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: default, one lane (64-bit beats, 17 payload beats)
    logic          a_valid, a_ready;
    logic [1023:0] a_data;
    logic [9:0]    a_dst;
    logic [1:0]    a_ttl, a_rid;
    logic          a_tvalid, a_tready, a_tlast;
    logic [63:0]   a_tdata;
    logic          a_done, a_drop;

    // Instance B: two lanes (128-bit beats, 9 payload beats)
    logic          b_valid, b_ready;
    logic [1023:0] b_data;
    logic [9:0]    b_dst;
    logic [1:0]    b_ttl, b_rid;
    logic          b_tvalid, b_tready, b_tlast;
    logic [127:0]  b_tdata;
    logic          b_done, b_drop;

    aurora_tx_serializer u_dut_a (
        .clk(clk), .rst(rst),
        .send_data_valid(a_valid), .send_data_ready(a_ready),
        .v_data_read(a_data), .dst_addr_send(a_dst),
        .TTL_send(a_ttl), .router_id_send(a_rid),
        .axis_tx_tvalid(a_tvalid), .axis_tx_tready(a_tready),
        .axis_tx_tlast(a_tlast), .axis_tx_tdata(a_tdata),
        .done_serializer(a_done), .drop_pulse(a_drop)
    );

    aurora_tx_serializer #(.NUMBER_OF_LANE(2)) u_dut_b (
        .clk(clk), .rst(rst),
        .send_data_valid(b_valid), .send_data_ready(b_ready),
        .v_data_read(b_data), .dst_addr_send(b_dst),
        .TTL_send(b_ttl), .router_id_send(b_rid),
        .axis_tx_tvalid(b_tvalid), .axis_tx_tready(b_tready),
        .axis_tx_tlast(b_tlast), .axis_tx_tdata(b_tdata),
        .done_serializer(b_done), .drop_pulse(b_drop)
    );

    typedef struct {
        logic [127:0] d;
        logic         last;
    } beat_t;

    typedef struct {
        logic [9:0]  dst;
        logic [1:0]  ttl;
        logic [1:0]  rid;
        int          pat;      // 0 incrementing bytes, 1 all ones, 2 random
        int          mode;     // tready: 0 always 1, 1 random 50%, 2 held 0
        logic [63:0] exp_hdr;
        bit          exp_drop;
    } vec_t;

    beat_t qa[$];
    beat_t qb[$];
    vec_t  vecs[4];

    int n_checks = 0;
    int n_fail   = 0;
    int a_mode = 0, b_mode = 0;
    int a_hs_cnt = 0, b_hs_cnt = 0;
    int a_done_cnt = 0, a_drop_cnt = 0, b_done_cnt = 0, b_drop_cnt = 0;
    int a_tvalid_samples = 0;
    logic         a_prev_stall = 1'b0, b_prev_stall = 1'b0;
    logic [127:0] a_prev_d = '0, b_prev_d = '0;
    logic         a_prev_last = 1'b0, b_prev_last = 1'b0;
    logic         a_done_s = 1'b0, b_done_s = 1'b0, b_ready_s = 1'b0, b_tvalid_s = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [1023:0] make_data(input int pat);
        logic [1023:0] d;
        for (int i = 0; i < 128; i++) begin
            if (pat == 0)      d[i*8 +: 8] = 8'(i);
            else if (pat == 1) d[i*8 +: 8] = 8'hFF;
            else               d[i*8 +: 8] = 8'($urandom);
        end
        return d;
    endfunction

    // Reference payload beat, built bit by bit from the message.
    function automatic logic [127:0] exp_payload(input int w, input int k,
                                                 input logic [1023:0] d, input logic [1:0] rid);
        logic [127:0] b;
        int hp;
        b  = '0;
        hp = w - 3;
        b[2:1] = rid;
        for (int j = 0; j < hp; j++) begin
            int idx;
            idx = k * hp + j;
            if (idx < 1024) b[3 + j] = d[idx];
        end
        return b;
    endfunction

    task automatic push_frame(input int lane2, input logic [1023:0] d, input logic [9:0] dst,
                              input logic [1:0] ttl, input logic [1:0] rid);
        beat_t e;
        int w, nb;
        w  = (lane2 != 0) ? 128 : 64;
        nb = (lane2 != 0) ? 9 : 17;
        e.d = 128'({dst, ttl, rid, 1'b1});
        e.last = 1'b0;
        if (lane2 != 0) qb.push_back(e); else qa.push_back(e);
        for (int k = 0; k < nb; k++) begin
            e.d = exp_payload(w, k, d, rid);
            e.last = (k == nb - 1);
            if (lane2 != 0) qb.push_back(e); else qa.push_back(e);
        end
    endtask

    // One clock: sample/check at the negedge, then advance past the posedge.
    task automatic step();
        beat_t e;
        @(negedge clk);
        if (a_prev_stall) begin
            chk("A stall tvalid", 128'(a_tvalid), 128'(1));
            chk("A stall tdata", 128'(a_tdata), a_prev_d);
            chk("A stall tlast", 128'(a_tlast), 128'(a_prev_last));
        end
        if (a_tvalid && a_tready) begin
            a_hs_cnt++;
            if (qa.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL A unexpected beat: got %h expected none", a_tdata);
            end else begin
                e = qa.pop_front();
                chk("A tdata", 128'(a_tdata), e.d);
                chk("A tlast", 128'(a_tlast), 128'(e.last));
            end
        end
        a_prev_stall = a_tvalid && !a_tready && !rst;
        a_prev_d     = 128'(a_tdata);
        a_prev_last  = a_tlast;
        a_done_s     = a_done;
        if (a_tvalid) a_tvalid_samples++;
        if (a_done) a_done_cnt++;
        if (a_drop) a_drop_cnt++;
        chk("A done/drop exclusive", 128'(a_done & a_drop), 128'(0));

        if (b_prev_stall) begin
            chk("B stall tvalid", 128'(b_tvalid), 128'(1));
            chk("B stall tdata", b_tdata, b_prev_d);
            chk("B stall tlast", 128'(b_tlast), 128'(b_prev_last));
        end
        if (b_tvalid && b_tready) begin
            b_hs_cnt++;
            if (qb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL B unexpected beat: got %h expected none", b_tdata);
            end else begin
                e = qb.pop_front();
                chk("B tdata", b_tdata, e.d);
                chk("B tlast", 128'(b_tlast), 128'(e.last));
            end
        end
        b_prev_stall = b_tvalid && !b_tready && !rst;
        b_prev_d     = b_tdata;
        b_prev_last  = b_tlast;
        b_done_s     = b_done;
        b_ready_s    = b_ready;
        b_tvalid_s   = b_tvalid;
        if (b_done) b_done_cnt++;
        if (b_drop) b_drop_cnt++;
        chk("B done/drop exclusive", 128'(b_done & b_drop), 128'(0));

        @(posedge clk);
        #1;
        if (a_mode == 1)      a_tready = 1'($urandom_range(0, 1));
        else if (a_mode == 0) a_tready = 1'b1;
        else                  a_tready = 1'b0;
        if (b_mode == 1)      b_tready = 1'($urandom_range(0, 1));
        else if (b_mode == 0) b_tready = 1'b1;
        else                  b_tready = 1'b0;
    endtask

    task automatic run_frame_a(input vec_t v);
        logic [1023:0] d;
        int hs0, done0, drop0, tv0, n;
        d     = make_data(v.pat);
        hs0   = a_hs_cnt;
        done0 = a_done_cnt;
        drop0 = a_drop_cnt;
        tv0   = a_tvalid_samples;
        chk("A ready before request", 128'(a_ready), 128'(1));
        a_mode   = v.mode;
        a_tready = 1'(v.mode != 2);
        a_valid  = 1'b1;
        a_data   = d;
        a_dst    = v.dst;
        a_ttl    = v.ttl;
        a_rid    = v.rid;
        if (v.ttl != 2'd0) push_frame(0, d, v.dst, v.ttl, v.rid);
        step();
        // Inputs scrambled after acceptance must not affect the frame
        a_valid = 1'b0;
        a_data  = ~d;
        a_dst   = ~v.dst;
        a_ttl   = 2'd3;
        a_rid   = ~v.rid;
        if (v.exp_drop) begin
            chk("A drop_pulse", 128'(a_drop), 128'(1));
            chk("A tvalid after drop", 128'(a_tvalid), 128'(0));
            chk("A ready after drop", 128'(a_ready), 128'(1));
            repeat (4) step();
            chk("A drop count", 128'(a_drop_cnt - drop0), 128'(1));
            chk("A done on drop", 128'(a_done_cnt - done0), 128'(0));
            chk("A tvalid during drop", 128'(a_tvalid_samples - tv0), 128'(0));
            chk("A beats on drop", 128'(a_hs_cnt - hs0), 128'(0));
        end else begin
            chk("A header", 128'(a_tdata), 128'(v.exp_hdr));
            chk("A header tvalid", 128'(a_tvalid), 128'(1));
            chk("A header tlast", 128'(a_tlast), 128'(0));
            n = 0;
            do begin
                step();
                n++;
            end while (!a_done_s && n < 400);
            chk("A frame completes", 128'(a_done_s), 128'(1));
            if (v.mode == 0) chk("A frame cycles", 128'(n), 128'(19));
            chk("A handshakes", 128'(a_hs_cnt - hs0), 128'(18));
            chk("A queue drained", 128'(qa.size()), 128'(0));
            step();
            chk("A done width", 128'(a_done_s), 128'(0));
            chk("A done count", 128'(a_done_cnt - done0), 128'(1));
            chk("A no drop", 128'(a_drop_cnt - drop0), 128'(0));
        end
        qa.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1023:0] d1, d2;
        int hs0, done0, n;

        vecs[0] = '{dst: 10'h2A5, ttl: 2'd2, rid: 2'd1, pat: 0, mode: 0, exp_hdr: 64'h54B3, exp_drop: 1'b0};
        vecs[1] = '{dst: 10'h3FF, ttl: 2'd3, rid: 2'd3, pat: 1, mode: 1, exp_hdr: 64'h7FFF, exp_drop: 1'b0};
        vecs[2] = '{dst: 10'h000, ttl: 2'd1, rid: 2'd2, pat: 2, mode: 1, exp_hdr: 64'h000D, exp_drop: 1'b0};
        vecs[3] = '{dst: 10'h155, ttl: 2'd0, rid: 2'd1, pat: 0, mode: 0, exp_hdr: 64'h0,    exp_drop: 1'b1};

        rst = 1'b1;
        a_valid = 1'b0; a_data = '0; a_dst = '0; a_ttl = '0; a_rid = '0; a_tready = 1'b1;
        b_valid = 1'b0; b_data = '0; b_dst = '0; b_ttl = '0; b_rid = '0; b_tready = 1'b1;

        // Reset state
        repeat (3) step();
        chk("reset A tvalid", 128'(a_tvalid), 128'(0));
        chk("reset A tlast", 128'(a_tlast), 128'(0));
        chk("reset A tdata", 128'(a_tdata), 128'(0));
        chk("reset A done", 128'(a_done), 128'(0));
        chk("reset A drop", 128'(a_drop), 128'(0));
        chk("reset A ready", 128'(a_ready), 128'(0));
        chk("reset B tvalid", 128'(b_tvalid), 128'(0));
        chk("reset B ready", 128'(b_ready), 128'(0));
        rst = 1'b0;
        #1;
        chk("A ready after reset", 128'(a_ready), 128'(1));
        chk("B ready after reset", 128'(b_ready), 128'(1));
        step();

        // Table-driven frames: continuous, backpressure+all-ones padding, random, TTL drop
        for (int i = 0; i < 4; i++) begin
            run_frame_a(vecs[i]);
            $display("vector %0d: dst=%h ttl=%0d rid=%0d checks=%0d fails=%0d",
                     i, vecs[i].dst, vecs[i].ttl, vecs[i].rid, n_checks, n_fail);
        end

        // Reset while payload beat 7 is on the bus
        d1 = make_data(2);
        a_mode = 0; a_tready = 1'b1;
        push_frame(0, d1, 10'h0AA, 2'd1, 2'd3);
        a_valid = 1'b1; a_data = d1; a_dst = 10'h0AA; a_ttl = 2'd1; a_rid = 2'd3;
        hs0 = a_hs_cnt;
        done0 = a_done_cnt;
        step();
        a_valid = 1'b0;
        n = 0;
        while ((a_hs_cnt - hs0) < 8 && n < 100) begin
            step();
            n++;
        end
        chk("A beats before reset", 128'(a_hs_cnt - hs0), 128'(8));
        a_mode = 2; a_tready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("A mid reset tvalid", 128'(a_tvalid), 128'(0));
        chk("A mid reset tlast", 128'(a_tlast), 128'(0));
        chk("A mid reset tdata", 128'(a_tdata), 128'(0));
        chk("A mid reset idle", 128'(a_ready), 128'(1));
        qa.delete();
        repeat (3) step();
        chk("A no done after abort", 128'(a_done_cnt - done0), 128'(0));
        run_frame_a(vecs[0]);
        $display("reset mid-frame: checks=%0d fails=%0d", n_checks, n_fail);

        // Two lanes, back-to-back requests with valid held high
        d1 = make_data(2);
        d2 = make_data(1);
        b_mode = 0; b_tready = 1'b1;
        hs0 = b_hs_cnt;
        done0 = b_done_cnt;
        push_frame(1, d1, 10'h123, 2'd1, 2'd2);
        push_frame(1, d2, 10'h0F0, 2'd3, 2'd1);
        b_valid = 1'b1; b_data = d1; b_dst = 10'h123; b_ttl = 2'd1; b_rid = 2'd2;
        step();
        b_data = d2; b_dst = 10'h0F0; b_ttl = 2'd3; b_rid = 2'd1;
        chk("B header 1", b_tdata, 128'h246D);
        n = 0;
        do begin
            step();
            n++;
        end while (!b_done_s && n < 200);
        chk("B frame 1 cycles", 128'(n), 128'(11));
        chk("B ready in done cycle", 128'(b_ready_s), 128'(1));
        chk("B tvalid in done cycle", 128'(b_tvalid_s), 128'(0));
        b_valid = 1'b0;
        chk("B header 2", b_tdata, 128'h1E1B);
        n = 0;
        do begin
            step();
            n++;
        end while (!b_done_s && n < 200);
        chk("B frame 2 cycles", 128'(n), 128'(11));
        chk("B handshakes", 128'(b_hs_cnt - hs0), 128'(20));
        chk("B queue drained", 128'(qb.size()), 128'(0));
        chk("B done count", 128'(b_done_cnt - done0), 128'(2));
        chk("B no drops", 128'(b_drop_cnt), 128'(0));
        $display("two-lane back-to-back: checks=%0d fails=%0d", n_checks, n_fail);

        repeat (2) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
